// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge arbiter.
// State encodings, timeout fill data and a width helper.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_bridge_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: search begins one past last_grant.
// Zero latency; no backpressure, valid is low when nothing requests.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_grant,
  output logic               vld,
  output logic [2:0]         idx
);

  logic [3:0] cand;

  always_comb begin
    vld  = 1'b0;
    idx  = 3'd0;
    cand = 4'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = 4'(last_grant) + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!vld && cand == 4'(j) && req[j]) begin
          vld = 1'b1;
          idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_bridge_arbiter.sv
// Round-robin arbiter sharing one qsys bridge port; grant held until acknowledge or watchdog expiry.
// Request to req_ack in 2+ cycles; losing requesters wait indefinitely, nothing is dropped.
module uart_bridge_arbiter
  import uart_bridge_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [4*NUM_REQ-1:0]      req_byte_enable,
  input  logic [ADDR_W*NUM_REQ-1:0] req_address,
  input  logic [32*NUM_REQ-1:0]     req_write_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic [31:0]               req_read_data,
  output logic                      bridge_read,
  output logic                      bridge_write,
  output logic [3:0]                bridge_byte_enable,
  output logic [ADDR_W-1:0]         bridge_address,
  output logic [31:0]               bridge_write_data,
  input  logic                      bridge_acknowledge,
  input  logic [31:0]               bridge_read_data,
  output logic                      busy,
  output logic [2:0]                grant_idx,
  output logic [7:0]                timeout_count
);

  localparam int WD_W = clog2(TIMEOUT);

  state_t              state_q, state_d;
  logic [2:0]          last_grant_q, last_grant_d;
  logic [2:0]          grant_q, grant_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [7:0]          tcount_q, tcount_d;

  logic [NUM_REQ-1:0]  req_any;
  logic                pick_vld;
  logic [2:0]          pick_idx;
  logic                sel_rd, sel_wr;
  logic [3:0]          sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [NUM_REQ-1:0]  grant_oh;

  assign req_any = req_read | req_write;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req       (req_any),
    .last_grant(last_grant_q),
    .vld       (pick_vld),
    .idx       (pick_idx)
  );

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_be    = 4'd0;
    sel_addr  = '0;
    sel_wdata = 32'd0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_rd    = req_read[i];
        sel_wr    = req_write[i];
        sel_be    = req_byte_enable[4*i +: 4];
        sel_addr  = req_address[ADDR_W*i +: ADDR_W];
        sel_wdata = req_write_data[32*i +: 32];
      end
      grant_oh[i] = (grant_q == 3'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    wdog_d       = wdog_q;
    tcount_d     = tcount_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d      = BUSY;
          last_grant_d = pick_idx;
          grant_d      = pick_idx;
          // read+write together is treated as a write
          rd_d         = sel_rd & ~sel_wr;
          wr_d         = sel_wr;
          be_d         = sel_be;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          wdog_d       = '0;
          busy_d       = 1'b1;
        end
      end
      BUSY: begin
        if (bridge_acknowledge) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rdata_d = bridge_read_data;
          ack_d   = grant_oh;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rdata_d = TIMEOUT_DATA;
          err_d   = 1'b1;
          ack_d   = grant_oh;
          if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      grant_q      <= 3'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      be_q         <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      wdog_q       <= '0;
      tcount_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      wdog_q       <= wdog_d;
      tcount_q     <= tcount_d;
    end
  end

  assign req_ack            = ack_q;
  assign req_err            = err_q;
  assign req_read_data      = rdata_q;
  assign bridge_read        = rd_q;
  assign bridge_write       = wr_q;
  assign bridge_byte_enable = be_q;
  assign bridge_address     = addr_q;
  assign bridge_write_data  = wdata_q;
  assign busy               = busy_q;
  assign grant_idx          = grant_q;
  assign timeout_count      = tcount_q;

endmodule

// File: tb/tb_uart_bridge_arbiter.sv
// Directed bench for uart_bridge_arbiter: vector table of single transactions plus
// hand sequences for idle acknowledge, mid-transaction reset and continuous requests.
module tb_uart_bridge_arbiter;

  localparam int NR = 2;
  localparam int AW = 9;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            nreset = 1'b0;
  logic [NR-1:0]   req_read = '0;
  logic [NR-1:0]   req_write = '0;
  logic [4*NR-1:0] req_byte_enable = '0;
  logic [AW*NR-1:0] req_address = '0;
  logic [32*NR-1:0] req_write_data = '0;
  logic [NR-1:0]   req_ack;
  logic            req_err;
  logic [31:0]     req_read_data;
  logic            bridge_read, bridge_write;
  logic [3:0]      bridge_byte_enable;
  logic [AW-1:0]   bridge_address;
  logic [31:0]     bridge_write_data;
  logic            bridge_acknowledge = 1'b0;
  logic [31:0]     bridge_read_data = '0;
  logic            busy;
  logic [2:0]      grant_idx;
  logic [7:0]      timeout_count;

  always #5 clock = ~clock;

  uart_bridge_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock             (clock),
    .nreset            (nreset),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_byte_enable   (req_byte_enable),
    .req_address       (req_address),
    .req_write_data    (req_write_data),
    .req_ack           (req_ack),
    .req_err           (req_err),
    .req_read_data     (req_read_data),
    .bridge_read       (bridge_read),
    .bridge_write      (bridge_write),
    .bridge_byte_enable(bridge_byte_enable),
    .bridge_address    (bridge_address),
    .bridge_write_data (bridge_write_data),
    .bridge_acknowledge(bridge_acknowledge),
    .bridge_read_data  (bridge_read_data),
    .busy              (busy),
    .grant_idx         (grant_idx),
    .timeout_count     (timeout_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [8:0]  a0, a1;
    logic [31:0] wd0, wd1;
    logic [3:0]  be0, be1;
    int          ack_at;
    logic [31:0] bdata;
    logic [2:0]  g;
    logic        erd, ewr, eerr;
    logic [31:0] edata;
    int          estb;
    logic [7:0]  etc;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [8:0] a0, input logic [8:0] a1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input logic [3:0] be0, input logic [3:0] be1,
                              input int ack_at, input logic [31:0] bdata,
                              input logic [2:0] g, input logic erd, input logic ewr,
                              input logic eerr, input logic [31:0] edata,
                              input int estb, input logic [7:0] etc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.be0 = be0; v.be1 = be1; v.ack_at = ack_at; v.bdata = bdata; v.g = g;
    v.erd = erd; v.ewr = ewr; v.eerr = eerr; v.edata = edata; v.estb = estb; v.etc = etc;
    return v;
  endfunction

  // Counts strobe-high cycles; acks in strobe cycle ack_at (0 = never). Returns in the req_ack cycle.
  task automatic wait_done(input int ack_at, input logic [31:0] bd, output int nstb);
    nstb = 0;
    bridge_read_data = bd;
    while ((bridge_read || bridge_write) && nstb < 200) begin
      nstb++;
      if (nstb == ack_at) bridge_acknowledge = 1'b1;
      step();
      bridge_acknowledge = 1'b0;
    end
    if (nstb >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL strobe_bound: strobe still high after %0d cycles", nstb);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int nstb;
    vec_t v;
    logic [1:0] eack;

    tbl[0] = mk(2'b01, 2'b00, 9'h010, 9'h1A5, 32'h1111_0000, 32'h2222_0000, 4'hF, 4'h3,
                3, 32'h1234_5678, 3'd0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 3, 8'd0);
    tbl[1] = mk(2'b10, 2'b10, 9'h010, 9'h0A5, 32'h1111_0000, 32'hA5A5_A5A5, 4'hF, 4'hC,
                1, 32'h0000_0042, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0042, 1, 8'd0);
    tbl[2] = mk(2'b10, 2'b01, 9'h033, 9'h144, 32'hDEAD_0001, 32'h0000_0000, 4'h1, 4'h8,
                2, 32'h55AA_55AA, 3'd0, 1'b0, 1'b1, 1'b0, 32'h55AA_55AA, 2, 8'd0);
    tbl[3] = mk(2'b11, 2'b00, 9'h011, 9'h122, 32'h0, 32'h0, 4'h2, 4'h4,
                1, 32'hCAFE_F00D, 3'd1, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1, 8'd0);
    tbl[4] = mk(2'b00, 2'b10, 9'h000, 9'h1FF, 32'h0, 32'h7777_7777, 4'h0, 4'h5,
                0, 32'h0101_0101, 3'd1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, TO, 8'd1);
    tbl[5] = mk(2'b01, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0, 4'hF, 4'h0,
                TO, 32'h0BAD_F00D, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, TO, 8'd1);
    tbl[6] = mk(2'b01, 2'b01, 9'h0AA, 9'h000, 32'h3C3C_3C3C, 32'h0, 4'h6, 4'h0,
                TO - 1, 32'h0000_0000, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, TO - 1, 8'd1);
    tbl[7] = mk(2'b11, 2'b00, 9'h001, 9'h100, 32'h0, 32'h0, 4'h9, 4'hA,
                1, 32'hFFFF_0000, 3'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 1, 8'd1);

    // Reset state, before any clock edge is used
    #12;
    chk("rst_strobes", {bridge_read, bridge_write, busy, req_err}, 4'b0000);
    chk("rst_ack", req_ack, 2'b00);
    chk("rst_fields", {bridge_address, bridge_byte_enable, bridge_write_data, req_read_data}, '0);
    chk("rst_grant_tc", {grant_idx, timeout_count}, '0);
    @(negedge clock);
    nreset = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      v = tbl[k];
      req_read        = v.rd;
      req_write       = v.wr;
      req_byte_enable = {v.be1, v.be0};
      req_address     = {v.a1, v.a0};
      req_write_data  = {v.wd1, v.wd0};
      step();
      chk($sformatf("v%0d_grant", k), grant_idx, v.g);
      chk($sformatf("v%0d_strobe", k), {bridge_read, bridge_write, busy}, {v.erd, v.ewr, 1'b1});
      chk($sformatf("v%0d_addr", k), bridge_address, (v.g == 3'd0) ? v.a0 : v.a1);
      chk($sformatf("v%0d_be", k), bridge_byte_enable, (v.g == 3'd0) ? v.be0 : v.be1);
      if (v.ewr)
        chk($sformatf("v%0d_wdata", k), bridge_write_data, (v.g == 3'd0) ? v.wd0 : v.wd1);
      wait_done(v.ack_at, v.bdata, nstb);
      eack = (v.g == 3'd0) ? 2'b01 : 2'b10;
      chk($sformatf("v%0d_nstrobe", k), 64'(nstb), 64'(v.estb));
      chk($sformatf("v%0d_ack", k), req_ack, eack);
      chk($sformatf("v%0d_err", k), req_err, v.eerr);
      chk($sformatf("v%0d_rdata", k), req_read_data, v.edata);
      chk($sformatf("v%0d_tcount", k), timeout_count, v.etc);
      req_read  = '0;
      req_write = '0;
      step();
      chk($sformatf("v%0d_ack_clear", k), {req_ack, req_err, busy}, 4'b0000);
    end

    // Acknowledge with nothing in flight must not complete anything
    bridge_acknowledge = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_ack_ignored", {req_ack, bridge_read, bridge_write, busy}, 5'b00000);
    end
    bridge_acknowledge = 1'b0;

    // Reset while BUSY: requester 1 wins (last grant was 1, requester 0 idle)
    req_read    = 2'b10;
    req_address = {9'h155, 9'h0AA};
    step();
    chk("mid_busy_strobe", {bridge_read, busy, grant_idx}, {1'b1, 1'b1, 3'd1});
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_strobes", {bridge_read, bridge_write, busy, req_err, req_ack}, 6'b0);
    chk("mid_rst_fields", {bridge_address, bridge_byte_enable, bridge_write_data, req_read_data}, '0);
    chk("mid_rst_grant_tc", {grant_idx, timeout_count}, '0);
    req_read = '0;
    bridge_acknowledge = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_stale_ack", {req_ack, busy}, 3'b000);
    end
    bridge_acknowledge = 1'b0;

    // Both requesters held continuously: grants alternate starting at 0
    req_read        = 2'b11;
    req_address     = {9'h0C1, 9'h0C0};
    req_byte_enable = {4'h3, 4'hC};
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("rr%0d_grant", t), grant_idx, 3'(t % 2));
      chk($sformatf("rr%0d_addr", t), bridge_address, (t % 2 == 0) ? 9'h0C0 : 9'h0C1);
      chk($sformatf("rr%0d_be", t), bridge_byte_enable, (t % 2 == 0) ? 4'hC : 4'h3);
      wait_done(1, 32'h100 + 32'(t), nstb);
      chk($sformatf("rr%0d_ack", t), req_ack, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d_rdata", t), req_read_data, 32'h100 + 32'(t));
      step();
    end
    req_read = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
